rs_queue: RTL
=============

// Module: rs_queue
// PURPOSE
//   Reservation station receiving rs_entry_t inserts from dispatch (one per cycle, valid/ready).
//   Holds entries until both source operands are ready (CDB wakeup), then issues oldest-ready to its FU.
//   Instantiated once per FU class (ALU, BRU, LSU); in_ready_o feeds dispatch's rs_*_ready_i.
// PARAMETERS
//   DEPTH   8              number of entries (>=2)
//   PREG_W  ooop_types::PREG_W   physical register tag width
// PORTS
//   clk              in   1        clock
//   rst_n            in   1        asynchronous active-low reset
//   flush_i          in   1        discard all entries
//   in_valid_i       in   1        insert request from dispatch
//   in_ready_o       in/out out 1  space available (registered-count based)
//   in_entry_i       in   rs_entry_t  entry to insert
//   cdb_valid_i      in   1        completion broadcast valid
//   cdb_prd_i        in   PREG_W   physical tag becoming ready
//   issue_valid_o    out  1        an entry is ready to issue
//   issue_ready_i    in   1        FU accepts this cycle
//   issue_entry_o    out  rs_entry_t  selected entry (prs1_ready/prs2_ready = 1)
//   count_o          out  $clog2(DEPTH+1)  occupied entries
// BEHAVIOUR
//   - Reset: all slots invalid, age matrix cleared; in_ready_o=1, issue_valid_o=0, issue_entry_o='0, count_o=0.
//   - Interface decided: one clock; reset is asynchronous and active-low (clk, rst_n).
//   - Insert fires on in_valid_i && in_ready_o; written to lowest-index free slot; visible next cycle.
//   - in_ready_o = (count_o < DEPTH); no credit for same-cycle issue (full RS + issue still refuses insert).
//   - Operand ready: src ready if !rsN_used, or prsN_ready, or matched by CDB. Unused src always ready.
//   - Wakeup: each cycle cdb_valid_i sets prsN_ready in every valid entry whose prsN==cdb_prd_i.
//     Insert-time capture: entry being inserted is also compared to CDB that cycle; match stored as ready.
//   - Age: DEPTH x DEPTH age matrix; on insert new slot marked younger than all valid slots.
//   - Select: issue_valid_o = any valid entry eligible; issue_entry_o = oldest eligible (combinational).
//   - Issue fires on issue_valid_o && issue_ready_i; slot freed next cycle. Selection may change while
//     issue_ready_i low (an older entry may wake); FU samples only on the handshake cycle.
//   - Simultaneous insert+issue: both happen; count unchanged. Freed slot reusable next cycle.
//   - count_o: +1 insert, -1 issue, never wraps (insert blocked at DEPTH, issue needs count>0).
//   - flush_i: all slots invalid next cycle, count_o=0; flush wins over same-cycle insert and issue
//     (issue_valid_o forced 0 while flush_i high). Reset mid-operation: same as power-on.
// CONFIGURATION
//   RS_WAKEUP_BYPASS_EN defined: CDB match makes an entry eligible in the SAME cycle (back-to-back
//     dependent issue); issue_entry_o shows the bypassed ready bits =1. Inserting entry still not
//     eligible until next cycle.
//   Undefined: eligibility uses registered ready bits only; 1-cycle wakeup-to-issue latency.
// STRUCTURE
//   ooop_types: rs_entry_t, PREG_W, fu_type_t (existing); add RS_DEPTH default constant.
//   One sub-module: rs_age_select (age matrix update + oldest-eligible one-hot pick, parameter DEPTH).
//   Slot array, wakeup compare, free-slot priority encoder, counter in rs_queue.
// TESTING
//   1 Insert 3 entries all ready (rs*_used=0), issue_ready_i=1 -> issue in insertion order, 1/cycle, count 3->0.
//   2 Insert 8 non-ready, 9th in_valid_i -> in_ready_o=0 while count=8; issue one -> in_ready_o=1 next cycle.
//   3 Entry prs1=12 not ready, cdb_prd_i=12 pulse -> issue_valid_o next cycle (same cycle with _EN).
//   4 Insert prs2=5 in same cycle cdb_prd_i=5 -> entry stored ready, issues next cycle.
//   5 Older A waits, younger B ready; A wakes while issue_ready_i=0 -> A issued first when ready rises.
//   6 flush_i with in_valid_i=1 and 4 entries -> count_o=0, issue_valid_o=0, inserted entry dropped.

Source files
------------

// File: rtl/ooop_types.sv
// ----------------------------------------------------------------------------
// ooop_types: shared types for the out-of-order core slice.
//   PREG_W     physical register tag width
//   ROB_W      reorder-buffer index width
//   RS_DEPTH   default reservation-station depth
//   fu_type_t  functional-unit class an instruction is routed to
//   rs_entry_t one reservation-station entry as delivered by dispatch
// ----------------------------------------------------------------------------
package ooop_types;

    localparam int PREG_W   = 6;
    localparam int ROB_W    = 6;
    localparam int RS_DEPTH = 8;

    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_BRU = 2'd1,
        FU_LSU = 2'd2
    } fu_type_t;

    typedef struct packed {
        fu_type_t          fu;
        logic [ROB_W-1:0]  rob_idx;
        logic [3:0]        op;
        logic              rs1_used;
        logic [PREG_W-1:0] prs1;
        logic              prs1_ready;
        logic              rs2_used;
        logic [PREG_W-1:0] prs2;
        logic              prs2_ready;
        logic [PREG_W-1:0] prd;
        logic [15:0]       imm;
    } rs_entry_t;

endpackage

// File: rtl/rs_age_select.sv
// ----------------------------------------------------------------------------
// rs_age_select: age matrix for a reservation station plus oldest-eligible pick.
//   clk, rst_n   clock, asynchronous active-low reset
//   flush_i      clear the whole matrix
//   valid_i      slots currently occupied (registered view)
//   ins_en_i     a new entry is written this cycle
//   ins_idx_i    slot receiving the new entry
//   elig_i       slots that may issue this cycle
//   grant_o      one-hot: the oldest eligible slot (all zero when none)
// Matrix meaning: age_q[r][c] = 1 means slot r is older than slot c.
// ----------------------------------------------------------------------------
module rs_age_select #(
    parameter int DEPTH = 8,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic [DEPTH-1:0] valid_i,
    input  logic             ins_en_i,
    input  logic [IDX_W-1:0] ins_idx_i,
    input  logic [DEPTH-1:0] elig_i,
    output logic [DEPTH-1:0] grant_o
);

    logic [DEPTH-1:0] age_q [DEPTH];
    logic [DEPTH-1:0] age_d [DEPTH];

    // A new entry is younger than every occupied slot: its own row is cleared
    // and its column is set in every occupied row. Rows of freed slots may keep
    // stale bits; they are rewritten when the slot is reused and never matter
    // meanwhile because only eligible (hence valid) rows are consulted.
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            age_d[r] = age_q[r];
        end
        if (flush_i) begin
            for (int r = 0; r < DEPTH; r++) begin
                age_d[r] = '0;
            end
        end else if (ins_en_i) begin
            for (int r = 0; r < DEPTH; r++) begin
                if (IDX_W'(r) == ins_idx_i) begin
                    age_d[r] = '0;
                end else begin
                    age_d[r][ins_idx_i] = valid_i[r];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                age_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                age_q[r] <= age_d[r];
            end
        end
    end

    // Slot c wins when it is eligible and no other eligible slot is older.
    always_comb begin
        grant_o = '0;
        for (int c = 0; c < DEPTH; c++) begin
            logic blocked;
            blocked = 1'b0;
            for (int r = 0; r < DEPTH; r++) begin
                if (elig_i[r] && age_q[r][c]) begin
                    blocked = 1'b1;
                end
            end
            grant_o[c] = elig_i[c] && !blocked;
        end
    end

endmodule

// File: rtl/rs_queue.sv
// ----------------------------------------------------------------------------
// rs_queue: reservation station for one functional-unit class.
// Holds dispatched entries until both source operands are ready (CDB wakeup),
// then offers the oldest ready entry to the FU.
//   clk, rst_n      clock, asynchronous active-low reset
//   flush_i         discard all entries (wins over same-cycle insert/issue)
//   in_valid_i      insert request from dispatch
//   in_ready_o      space available, from the registered occupancy count
//   in_entry_i      entry to insert
//   cdb_valid_i     completion broadcast valid
//   cdb_prd_i       physical tag becoming ready
//   issue_valid_o   an entry is ready to issue
//   issue_ready_i   FU accepts this cycle
//   issue_entry_o   selected entry, ready bits shown as 1
//   count_o         number of occupied slots
// Configuration macro RS_WAKEUP_BYPASS_EN: when defined, a CDB match makes a
// stored entry eligible in the same cycle; otherwise only registered ready
// bits count (one cycle from broadcast to issue).
// ----------------------------------------------------------------------------
module rs_queue
    import ooop_types::*;
#(
    parameter int DEPTH  = RS_DEPTH,
    parameter int PREG_W = ooop_types::PREG_W,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  rs_entry_t         in_entry_i,
    input  logic              cdb_valid_i,
    input  logic [PREG_W-1:0] cdb_prd_i,
    output logic              issue_valid_o,
    input  logic              issue_ready_i,
    output rs_entry_t         issue_entry_o,
    output logic [CNT_W-1:0]  count_o
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DEPTH-1:0] valid_q, valid_d;
    rs_entry_t        entry_q [DEPTH];
    rs_entry_t        entry_d [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;

    logic [DEPTH-1:0] cdb_hit1, cdb_hit2;
    logic [DEPTH-1:0] src1_rdy, src2_rdy;
    logic [DEPTH-1:0] elig;
    logic [DEPTH-1:0] grant;
    logic [IDX_W-1:0] free_idx;
    logic             ins_fire, iss_fire;
    rs_entry_t        ins_entry;

    // ---------------- wakeup compare and eligibility ----------------
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        assign cdb_hit1[gi] = cdb_valid_i && (entry_q[gi].prs1 == cdb_prd_i);
        assign cdb_hit2[gi] = cdb_valid_i && (entry_q[gi].prs2 == cdb_prd_i);
`ifdef RS_WAKEUP_BYPASS_EN
        assign src1_rdy[gi] = !entry_q[gi].rs1_used || entry_q[gi].prs1_ready || cdb_hit1[gi];
        assign src2_rdy[gi] = !entry_q[gi].rs2_used || entry_q[gi].prs2_ready || cdb_hit2[gi];
`else
        assign src1_rdy[gi] = !entry_q[gi].rs1_used || entry_q[gi].prs1_ready;
        assign src2_rdy[gi] = !entry_q[gi].rs2_used || entry_q[gi].prs2_ready;
`endif
        assign elig[gi] = valid_q[gi] && src1_rdy[gi] && src2_rdy[gi];
    end

    // ---------------- handshakes ----------------
    assign in_ready_o    = (count_q < DEPTH_C);
    assign issue_valid_o = (|elig) && !flush_i;
    assign ins_fire      = in_valid_i && in_ready_o && !flush_i;
    assign iss_fire      = issue_valid_o && issue_ready_i;
    assign count_o       = count_q;

    // Lowest-index free slot; only used when in_ready_o guarantees one exists.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    // Incoming entry: unused sources are stored ready, and a broadcast in the
    // insert cycle is captured so the tag is not missed.
    always_comb begin
        ins_entry = in_entry_i;
        if (!in_entry_i.rs1_used || (cdb_valid_i && in_entry_i.prs1 == cdb_prd_i)) begin
            ins_entry.prs1_ready = 1'b1;
        end
        if (!in_entry_i.rs2_used || (cdb_valid_i && in_entry_i.prs2 == cdb_prd_i)) begin
            ins_entry.prs2_ready = 1'b1;
        end
    end

    rs_age_select #(
        .DEPTH (DEPTH)
    ) u_age (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (flush_i),
        .valid_i   (valid_q),
        .ins_en_i  (ins_fire),
        .ins_idx_i (free_idx),
        .elig_i    (elig),
        .grant_o   (grant)
    );

    // ---------------- slot array next state ----------------
    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = entry_q[i];
            // Waking an invalid slot is harmless; it is overwritten on insert.
            if (cdb_hit1[i]) begin
                entry_d[i].prs1_ready = 1'b1;
            end
            if (cdb_hit2[i]) begin
                entry_d[i].prs2_ready = 1'b1;
            end
        end
        if (iss_fire) begin
            valid_d = valid_d & ~grant;
        end
        if (ins_fire) begin
            valid_d[free_idx] = 1'b1;
            entry_d[free_idx] = ins_entry;
        end
        if (flush_i) begin
            valid_d = '0;
        end
    end

    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else begin
            unique case ({ins_fire, iss_fire})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

    // ---------------- issue mux ----------------
    // grant is one-hot or zero, so an AND-OR mux yields all zeros when idle.
    always_comb begin
        issue_entry_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                issue_entry_o = issue_entry_o | entry_q[i];
            end
        end
        if (|grant) begin
            issue_entry_o.prs1_ready = 1'b1;
            issue_entry_o.prs2_ready = 1'b1;
        end
    end

endmodule
